// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice.
//   alu_op_e    : 4-bit ALU control codes (unlisted codes behave as ADD)
//   arb_state_e : occupancy of the one-entry output register
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110
    } alu_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and one result consumer.
//   reqN_valid/ready/in1/in2/ctrl : request port N (N = 0, 1)
//   rsp_valid/ready/id/result/zero/sign : registered response port
// Modports: slave = arbiter side, master = requester/consumer side.
interface alu_arbiter_if #(
    parameter int REG_WIDTH = 32
);
    logic                 req0_valid, req0_ready;
    logic [REG_WIDTH-1:0] req0_in1, req0_in2;
    logic [3:0]           req0_ctrl;
    logic                 req1_valid, req1_ready;
    logic [REG_WIDTH-1:0] req1_in1, req1_in2;
    logic [3:0]           req1_ctrl;
    logic                 rsp_valid, rsp_ready;
    logic                 rsp_id;
    logic [REG_WIDTH-1:0] rsp_result;
    logic                 rsp_zero, rsp_sign;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_ctrl,
        input  req1_valid, req1_in1, req1_in2, req1_ctrl,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_ctrl,
        output req1_valid, req1_in1, req1_in2, req1_ctrl,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU.
//   in1, in2 : signed operands (two's complement, so add/sub are sign-agnostic)
//   ctrl     : operation code; any code not listed in alu_op_e adds
//   result   : operation result, wraps modulo 2^REG_WIDTH
//   zero     : result is all zeros
//   sign     : result MSB
module alu
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic [REG_WIDTH-1:0] in1,
    input  logic [REG_WIDTH-1:0] in2,
    input  logic [3:0]           ctrl,
    output logic [REG_WIDTH-1:0] result,
    output logic                 zero,
    output logic                 sign
);

    always_comb begin
        result = in1 + in2;
        case (ctrl)
            ALU_AND: result = in1 & in2;
            ALU_OR:  result = in1 | in2;
            ALU_XOR: result = in1 ^ in2;
            ALU_SUB: result = in1 - in2;
            default: result = in1 + in2;
        endcase
    end

    assign zero = (result == '0);
    assign sign = result[REG_WIDTH-1];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a one-entry
// registered output (one-cycle latency, full throughput).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if.slave (request ports 0/1, response port)
//   grant_cnt0/1 : saturating per-requester accept counters, present only
//                  when ALU_ARB_STATS_EN is defined
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);

    arb_state_e           state, state_nxt;
    logic                 last_gnt;   // requester granted at the last accept
    logic                 pick;       // requester that would win this cycle
    logic                 cap;
    logic                 accept;
    logic [REG_WIDTH-1:0] alu_in1, alu_in2, alu_res;
    logic [3:0]           alu_ctrl;
    logic                 alu_zero, alu_sign;

    // Capacity gated by rst_n so both readys drop the moment reset asserts.
    assign cap = rst_n && ((state == ST_EMPTY) || bus.rsp_ready);

    // Ready is driven from the arbitration result alone: an idle cycle
    // still offers ready to requester 0, so no port waits on its own valid.
    assign pick = (bus.req0_valid && bus.req1_valid) ? ~last_gnt : bus.req1_valid;

    assign bus.req0_ready = cap && !pick;
    assign bus.req1_ready = cap &&  pick;

    assign accept = (bus.req0_ready && bus.req0_valid) ||
                    (bus.req1_ready && bus.req1_valid);

    assign alu_in1  = pick ? bus.req1_in1  : bus.req0_in1;
    assign alu_in2  = pick ? bus.req1_in2  : bus.req0_in2;
    assign alu_ctrl = pick ? bus.req1_ctrl : bus.req0_ctrl;

    alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
        .in1    (alu_in1),
        .in2    (alu_in2),
        .ctrl   (alu_ctrl),
        .result (alu_res),
        .zero   (alu_zero),
        .sign   (alu_sign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL: begin
                if (accept)             state_nxt = ST_FULL;
                else if (bus.rsp_ready) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    assign bus.rsp_valid = (state == ST_FULL);

    // Output register loads only on accept, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_sign   <= 1'b0;
            bus.rsp_id     <= 1'b0;
            last_gnt       <= 1'b1;   // requester 0 wins first contention
        end else if (accept) begin
            bus.rsp_result <= alu_res;
            bus.rsp_zero   <= alu_zero;
            bus.rsp_sign   <= alu_sign;
            bus.rsp_id     <= pick;
            last_gnt       <= pick;
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!pick && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if ( pick && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table-driven single-requester vectors,
// round-robin, stall-hold and mid-cycle reset sequences, with a response
// scoreboard. The saturation test runs only when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        sign;
    } exp_t;

    typedef struct {
        logic        id;
        logic [31:0] in1, in2;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero, sign;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.REG_WIDTH(32)) bif();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    alu_arbiter #(.REG_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    bit   sb_en = 1'b1;
    bit   tab_en = 1'b0;
    exp_t tab_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] c);
        exp_t e;
        case (c)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0011: e.res = a ^ b;
            4'b0110: e.res = a - b;
            default: e.res = a + b;
        endcase
        e.id   = id;
        e.zero = (e.res == 32'd0);
        e.sign = e.res[31];
        return e;
    endfunction

    // Response monitor: pops the scoreboard on every response transfer.
    always @(negedge clk) begin
        if (rst_n && sb_en && bif.rsp_valid && bif.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got result %h with empty scoreboard", bif.rsp_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_result", bif.rsp_result, e.res);
                chk("rsp_id",     {31'd0, bif.rsp_id},   {31'd0, e.id});
                chk("rsp_zero",   {31'd0, bif.rsp_zero}, {31'd0, e.zero});
                chk("rsp_sign",   {31'd0, bif.rsp_sign}, {31'd0, e.sign});
            end
        end
    end

    // One cycle, entered and left at posedge+1. Expected accepts are pushed
    // from the expected readys, never from the DUT's.
    task automatic step(input bit v0, input bit v1, input bit rr, input bit er0, input bit er1);
        bif.req0_valid = v0;
        bif.req1_valid = v1;
        bif.rsp_ready  = rr;
        @(negedge clk);
        chk("req0_ready", {31'd0, bif.req0_ready}, {31'd0, er0});
        chk("req1_ready", {31'd0, bif.req1_ready}, {31'd0, er1});
        if (v0 && er0) exp_q.push_back(tab_en ? tab_e : model(1'b0, bif.req0_in1, bif.req0_in2, bif.req0_ctrl));
        if (v1 && er1) exp_q.push_back(tab_en ? tab_e : model(1'b1, bif.req1_in1, bif.req1_in2, bif.req1_ctrl));
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 32'd5,         32'd3,         4'b0110, 32'd2,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h7FFFFFFF,  32'd1,         4'b0010, 32'h80000000,  1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'hF0F0F0F0,  32'hFFFFFFFF,  4'b0011, 32'h0F0F0F0F,  1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'hF0F0F0F0,  32'h0F0F0F0F,  4'b0000, 32'h00000000,  1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'hF0F0F0F0,  32'h0F0F0F0F,  4'b0001, 32'hFFFFFFFF,  1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'd3,         32'd5,         4'b0110, 32'hFFFFFFFE,  1'b0, 1'b1};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,  32'd1,         4'b1111, 32'h00000000,  1'b1, 1'b0};
        vecs[7] = '{1'b1, 32'h12345678,  32'd1,         4'b0111, 32'h12345679,  1'b0, 1'b0};

        bif.req0_valid = 1'b1; bif.req1_valid = 1'b1; bif.rsp_ready = 1'b1;
        bif.req0_in1 = '0; bif.req0_in2 = '0; bif.req0_ctrl = '0;
        bif.req1_in1 = '0; bif.req1_in2 = '0; bif.req1_ctrl = '0;

        // Reset state, with both requesters pushing.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid",  {31'd0, bif.rsp_valid},  32'd0);
        chk("rst_rsp_result", bif.rsp_result,          32'd0);
        chk("rst_rsp_zero",   {31'd0, bif.rsp_zero},   32'd0);
        chk("rst_rsp_sign",   {31'd0, bif.rsp_sign},   32'd0);
        chk("rst_rsp_id",     {31'd0, bif.rsp_id},     32'd0);
        chk("rst_req0_ready", {31'd0, bif.req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, bif.req1_ready}, 32'd0);
        rst_n = 1'b1;

        // Round-robin from reset: 0,1,0,1,... with one result per cycle.
        for (int i = 0; i < 6; i++) begin
            bif.req0_in1 = i; bif.req0_in2 = 32'd100; bif.req0_ctrl = 4'b0010;
            bif.req1_in1 = i; bif.req1_in2 = 32'd100; bif.req1_ctrl = 4'b0110;
            step(1'b1, 1'b1, 1'b1, (i % 2) == 0, (i % 2) == 1);
        end

        // Table vectors, one requester at a time, back to back.
        tab_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tab_e = '{vecs[i].id, vecs[i].res, vecs[i].zero, vecs[i].sign};
            if (vecs[i].id) begin
                bif.req1_in1 = vecs[i].in1; bif.req1_in2 = vecs[i].in2; bif.req1_ctrl = vecs[i].ctrl;
            end else begin
                bif.req0_in1 = vecs[i].in1; bif.req0_in2 = vecs[i].in2; bif.req0_ctrl = vecs[i].ctrl;
            end
            step(!vecs[i].id, vecs[i].id, 1'b1, !vecs[i].id, vecs[i].id);
        end
        tab_en = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // drain last table result

        // Stall: req1 7-7 held for three cycles, no accepts while full.
        bif.req1_in1 = 32'd7; bif.req1_in2 = 32'd7; bif.req1_ctrl = 4'b0110;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        bif.req0_in1 = 32'd9; bif.req0_in2 = 32'd1; bif.req0_ctrl = 4'b0010;
        bif.req1_in1 = 32'd4; bif.req1_in2 = 32'd4; bif.req1_ctrl = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("stall_valid",  {31'd0, bif.rsp_valid}, 32'd1);
            chk("stall_result", bif.rsp_result,         32'd0);
            chk("stall_zero",   {31'd0, bif.rsp_zero},  32'd1);
            chk("stall_id",     {31'd0, bif.rsp_id},    32'd1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // drain

        // Reset while full and stalled, with requester 0 granted last.
        bif.req0_in1 = 32'd1; bif.req0_in2 = 32'd2; bif.req0_ctrl = 4'b0010;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_valid", {31'd0, bif.rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",  {31'd0, bif.rsp_valid},  32'd0);
        chk("async_rst_result", bif.rsp_result,          32'd0);
        chk("async_rst_ready0", {31'd0, bif.req0_ready}, 32'd0);
        exp_q.delete();                       // held result is discarded
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bif.req0_in1 = 32'd10; bif.req0_in2 = 32'd3; bif.req0_ctrl = 4'b0110;
        bif.req1_in1 = 32'd20; bif.req1_in2 = 32'd3; bif.req1_ctrl = 4'b0110;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // drain

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drained: got %0d pending expected 0", exp_q.size());
        end

`ifdef ALU_ARB_STATS_EN
        rst_n = 1'b0;
        #2;
        chk("cnt0_reset", {16'd0, grant_cnt0}, 32'd0);
        chk("cnt1_reset", {16'd0, grant_cnt1}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_en = 1'b0;
        bif.req0_valid = 1'b1; bif.req1_valid = 1'b0; bif.rsp_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        bif.req0_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("cnt0_sat", {16'd0, grant_cnt0}, 32'h0000FFFF);
        chk("cnt1_sat", {16'd0, grant_cnt1}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter REG_WIDTH, default 32, SHALL set the operand and result width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 reqN_valid  input  1  (N=0,1) SHALL flag a pending operation from requester N.
REQ-005 reqN_ready  output  1  SHALL flag acceptance of requester N's operation this cycle.
REQ-006 reqN_in1, reqN_in2  input  REG_WIDTH  SHALL carry requester N's signed operands.
REQ-007 reqN_ctrl  input  4  SHALL carry requester N's ALU control code.
REQ-008 rsp_valid  output  1  SHALL flag a valid result in the output register.
REQ-009 rsp_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-010 rsp_id  output  1  SHALL identify the requester that owns the result.
REQ-011 rsp_result  output  REG_WIDTH; rsp_zero, rsp_sign  output  1  SHALL carry the registered result, zero flag and sign flag.

Function
REQ-012 A transfer on request port N SHALL occur when reqN_valid and reqN_ready are both high at a rising edge; the response side likewise with rsp_valid and rsp_ready.
REQ-013 The block SHALL hold a one-entry output register with states EMPTY and FULL; EMPTY->FULL on accept, FULL->EMPTY on drain without accept, FULL->FULL on drain with simultaneous accept or on stall.
REQ-014 Accept capacity SHALL be present when state is EMPTY, or FULL with rsp_ready high (same-cycle drain and refill, full throughput).
REQ-015 With capacity and one valid requester, that requester SHALL be granted; with both valid, the requester not granted last SHALL be granted (round-robin).
REQ-016 At most one reqN_ready SHALL be high per cycle; reqN_ready SHALL be low whenever there is no capacity; reqN_ready SHALL depend on reqN_valid only through arbitration, never wait for it.
REQ-017 The last-granted pointer SHALL update only on an actual accept.
REQ-018 Operation codes SHALL be: 0000 AND, 0001 OR, 0011 XOR, 0110 in1-in2; every other code in1+in2, wrapping modulo 2^REG_WIDTH.
REQ-019 rsp_zero SHALL be high iff rsp_result is all zeros; rsp_sign SHALL equal rsp_result[REG_WIDTH-1].
REQ-020 Latency SHALL be one cycle: an operation accepted at edge k is presented with rsp_valid high after edge k.
REQ-021 While rsp_valid is high and rsp_ready low, rsp_result, rsp_zero, rsp_sign and rsp_id SHALL be held stable.

Reset
REQ-022 On rst_n low, state SHALL become EMPTY immediately: rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_sign=0, rsp_id=0, both reqN_ready=0.
REQ-023 The last-granted pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-024 A result held at reset assertion SHALL be discarded; no transfer occurs while rst_n is low.

Configuration
REQ-025 With macro ALU_ARB_STATS_EN defined, outputs grant_cnt0 and grant_cnt1 (16 bits each) SHALL count accepts per requester, saturate at 16'hFFFF, and reset to 0.
REQ-026 Without ALU_ARB_STATS_EN, those ports and counters SHALL be absent and all other behaviour unchanged.

Structure
REQ-027 A shared package alu_pkg SHALL hold the 4-bit ALU opcode enum (AND, OR, XOR, SUB, ADD) and the FSM state typedef.
REQ-028 The combinational datapath SHALL be the existing alu module, instantiated once and fed by a grant-selected operand mux.

Verification
REQ-029 Req0 only, in1=5, in2=3, ctrl=0110, rsp_ready=1 -> one cycle later rsp_valid=1, result=2, id=0, zero=0, sign=0.
REQ-030 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 from reset; one result per cycle.
REQ-031 Req1 in1=7, in2=7, ctrl=0110, rsp_ready=0 for 3 cycles -> result=0, zero=1 held stable; both readys low until drain.
REQ-032 in1=32'h7FFFFFFF, in2=1, ctrl=0010 -> result=32'h80000000, sign=1 (wrap); ctrl=0011 with 32'hF0F0F0F0, 32'hFFFFFFFF -> 32'h0F0F0F0F.
REQ-033 rst_n pulsed low while FULL and stalled -> rsp_valid falls without a clock edge; next contention grants requester 0.
REQ-034 ALU_ARB_STATS_EN defined, 70000 requester-0 accepts -> grant_cnt0=16'hFFFF, grant_cnt1=0.
